// File: rtl/rsnn_serial_cfg_loader.sv
// Bit-serial configuration loader for the RSNN parameter/weight register file.
// Synchronises the pad pins, assembles LSB-first bytes and issues addressed byte writes.
module rsnn_serial_cfg_loader #(
    parameter int NUM_BYTES   = 39,
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cfg_mode,
    input  logic              cfg_strobe,
    input  logic              cfg_din,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cfg_done,
    output logic              cfg_overflow,
    output logic              run_en
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

    logic [SYNC_STAGES-1:0] r_mode_sync;
    logic [SYNC_STAGES-1:0] r_str_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_mode_d;
    logic                   r_str_d;

    state_t                 r_state;
    logic [7:0]             r_sr;
    logic [2:0]             r_bit_cnt;
    logic [ADDR_W-1:0]      r_byte_ptr;
    logic                   r_byte_rdy;
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [7:0]             r_wr_data;
    logic                   r_cfg_done;
    logic                   r_cfg_overflow;
    logic                   r_run_en;

    logic                   w_mode_s;
    logic                   w_din_s;
    logic                   w_mode_rise;
    logic                   w_str_rise;

    state_t                 w_state_nxt;
    logic [7:0]             w_sr_nxt;
    logic [2:0]             w_bit_cnt_nxt;
    logic [ADDR_W-1:0]      w_byte_ptr_nxt;
    logic                   w_byte_rdy_nxt;
    logic                   w_wr_en_nxt;
    logic [ADDR_W-1:0]      w_wr_addr_nxt;
    logic [7:0]             w_wr_data_nxt;
    logic                   w_cfg_done_nxt;
    logic                   w_cfg_overflow_nxt;
    logic                   w_run_en_nxt;

    assign w_mode_s    = r_mode_sync[SYNC_STAGES-1];
    assign w_din_s     = r_din_sync[SYNC_STAGES-1];
    assign w_mode_rise = w_mode_s & ~r_mode_d;
    assign w_str_rise  = r_str_sync[SYNC_STAGES-1] & ~r_str_d;

    // Pad synchronisers plus the edge-detect delay flops; these run regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_sync <= '0;
            r_str_sync  <= '0;
            r_din_sync  <= '0;
            r_mode_d    <= 1'b0;
            r_str_d     <= 1'b0;
        end else begin
            r_mode_sync <= {r_mode_sync[SYNC_STAGES-2:0], cfg_mode};
            r_str_sync  <= {r_str_sync[SYNC_STAGES-2:0], cfg_strobe};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], cfg_din};
            r_mode_d    <= w_mode_s;
            r_str_d     <= r_str_sync[SYNC_STAGES-1];
        end
    end

    // Next-state and next-output logic for the load FSM.
    always_comb begin
        w_state_nxt        = r_state;
        w_sr_nxt           = r_sr;
        w_bit_cnt_nxt      = r_bit_cnt;
        w_byte_ptr_nxt     = r_byte_ptr;
        w_byte_rdy_nxt     = r_byte_rdy;
        w_wr_en_nxt        = 1'b0;
        w_wr_addr_nxt      = r_wr_addr;
        w_wr_data_nxt      = r_wr_data;
        w_cfg_done_nxt     = r_cfg_done;
        w_cfg_overflow_nxt = r_cfg_overflow;
        case (r_state)
            ST_IDLE: begin
                if (w_mode_rise) begin
                    w_state_nxt        = ST_LOAD;
                    w_byte_ptr_nxt     = '0;
                    w_bit_cnt_nxt      = 3'd0;
                    w_byte_rdy_nxt     = 1'b0;
                    w_cfg_done_nxt     = 1'b0;
                    w_cfg_overflow_nxt = 1'b0;
                end else begin
                    w_byte_rdy_nxt = 1'b0;
                end
            end
            ST_LOAD: begin
                if (!w_mode_s) begin
                    // Early exit: any partial byte (and an unissued write) is dropped.
                    w_state_nxt    = ST_IDLE;
                    w_bit_cnt_nxt  = 3'd0;
                    w_byte_rdy_nxt = 1'b0;
                end else begin
                    if (r_byte_rdy) begin
                        w_wr_en_nxt    = 1'b1;
                        w_wr_addr_nxt  = r_byte_ptr;
                        w_wr_data_nxt  = r_sr;
                        w_byte_ptr_nxt = r_byte_ptr + ADDR_W'(1);
                        w_byte_rdy_nxt = 1'b0;
                        if (r_byte_ptr == LAST_ADDR) begin
                            w_state_nxt    = ST_DONE;
                            w_cfg_done_nxt = 1'b1;
                        end else begin
                            w_cfg_done_nxt = r_cfg_done;
                        end
                    end else begin
                        w_byte_rdy_nxt = r_byte_rdy;
                    end
                    if (ena && w_str_rise) begin
                        w_sr_nxt      = {w_din_s, r_sr[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_byte_rdy_nxt = 1'b1;
                        end else begin
                            w_byte_rdy_nxt = w_byte_rdy_nxt;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt;
                    end
                end
            end
            ST_DONE: begin
                if (!w_mode_s) begin
                    w_state_nxt   = ST_IDLE;
                    w_bit_cnt_nxt = 3'd0;
                end else if (ena && w_str_rise) begin
                    w_cfg_overflow_nxt = 1'b1;
                end else begin
                    w_cfg_overflow_nxt = r_cfg_overflow;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_bit_cnt_nxt  = 3'd0;
                w_byte_rdy_nxt = 1'b0;
            end
        endcase
        w_run_en_nxt = (w_state_nxt == ST_IDLE) & w_cfg_done_nxt;
    end

    // FSM, datapath and registered output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_sr           <= 8'd0;
            r_bit_cnt      <= 3'd0;
            r_byte_ptr     <= '0;
            r_byte_rdy     <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= 8'd0;
            r_cfg_done     <= 1'b0;
            r_cfg_overflow <= 1'b0;
            r_run_en       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sr           <= w_sr_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_byte_ptr     <= w_byte_ptr_nxt;
            r_byte_rdy     <= w_byte_rdy_nxt;
            r_wr_en        <= w_wr_en_nxt;
            r_wr_addr      <= w_wr_addr_nxt;
            r_wr_data      <= w_wr_data_nxt;
            r_cfg_done     <= w_cfg_done_nxt;
            r_cfg_overflow <= w_cfg_overflow_nxt;
            r_run_en       <= w_run_en_nxt;
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign cfg_done     = r_cfg_done;
    assign cfg_overflow = r_cfg_overflow;
    assign run_en       = r_run_en;

endmodule

// File: tb/tb_rsnn_serial_cfg_loader.sv
// Directed/random bench for rsnn_serial_cfg_loader with a byte-level reference model.
module tb_rsnn_serial_cfg_loader;

    localparam int NB = 39;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       cfg_mode = 1'b0;
    logic       cfg_strobe = 1'b0;
    logic       cfg_din = 1'b0;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       cfg_done;
    logic       cfg_overflow;
    logic       run_en;

    rsnn_serial_cfg_loader #(.NUM_BYTES(39), .ADDR_W(6), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_mode(cfg_mode),
        .cfg_strobe(cfg_strobe), .cfg_din(cfg_din), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .cfg_done(cfg_done),
        .cfg_overflow(cfg_overflow), .run_en(run_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int t_hi = 0;
    int last_wr_cyc = -1;
    logic [13:0] obs_q[$];
    logic [13:0] exp_q[$];

    // Reference model state: what an ideal loader would have done with the bits sent.
    bit   m_mode = 0;
    int   m_ptr = 0;
    int   m_nbits = 0;
    int   m_acc = 0;
    bit   m_done = 0;
    bit   m_ovf = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            obs_q.push_back({wr_addr, wr_data});
            last_wr_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_enter();
        m_mode = 1; m_ptr = 0; m_nbits = 0; m_acc = 0; m_done = 0; m_ovf = 0;
    endtask

    task automatic model_exit();
        m_mode = 0; m_nbits = 0; m_acc = 0;
    endtask

    task automatic model_bit(input bit b);
        if (m_mode && ena) begin
            if (m_done) begin
                m_ovf = 1;
            end else begin
                m_acc = m_acc + (int'(b) << m_nbits);
                m_nbits++;
                if (m_nbits == 8) begin
                    exp_q.push_back({6'(m_ptr), 8'(m_acc)});
                    m_ptr++;
                    m_nbits = 0;
                    m_acc = 0;
                    if (m_ptr == NB) m_done = 1;
                end
            end
        end
    endtask

    task automatic send_bit(input bit b, input int hi, input int lo);
        model_bit(b);
        cfg_din = b;
        cfg_strobe = 1'b1;
        t_hi = cyc;
        repeat (hi) @(negedge clk);
        cfg_strobe = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input int hi, input int lo);
        for (int i = 0; i < 8; i++) send_bit(v[i], hi, lo);
    endtask

    task automatic send_byte_rand(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i], int'($urandom_range(1, 6)), int'($urandom_range(2, 4)));
    endtask

    task automatic enter_cfg();
        model_enter();
        cfg_mode = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic exit_cfg();
        model_exit();
        cfg_mode = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        int n;
        repeat (6) @(negedge clk);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_done"}, cfg_done, m_done);
        chk({tag, "_ovf"}, cfg_overflow, m_ovf);
        chk({tag, "_run"}, run_en, !m_mode && m_done);
    endtask

    logic [7:0] plan[NB];

    initial begin
        for (int i = 0; i < NB; i++) plan[i] = 8'h01;
        for (int l = 0; l < 3; l++) begin
            plan[l*4+1] = 8'h04;
            plan[l*4+3] = 8'h1F;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 6'd0);
        chk("rst_wr_data", wr_data, 8'd0);
        check_status("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full load with the test-plan byte pattern, plus first-write latency
        enter_cfg();
        send_byte(plan[0], 5, 2);
        chk("latency", last_wr_cyc, t_hi + 4);
        for (int i = 1; i < NB; i++) send_byte(plan[i], 5, 2);
        check_writes("full");
        check_status("full_in_cfg");
        exit_cfg();
        check_status("full_run");

        // Strobes while idle are ignored
        send_byte(8'hFF, 2, 2);
        send_byte(8'h3C, 2, 2);
        check_writes("idle");
        check_status("idle");

        // Random full load with random strobe timing, then overflow
        enter_cfg();
        check_status("reenter");
        for (int i = 0; i < NB; i++) send_byte_rand(8'($urandom));
        check_writes("rand_full");
        check_status("rand_done");
        send_bit(1'b1, 3, 2);
        check_writes("ovf");
        check_status("ovf");
        exit_cfg();
        check_status("ovf_run");
        enter_cfg();
        check_status("ovf_clear");

        // Bit order, then abort after 3 bytes + 5 bits
        send_byte_rand(8'hA5);
        send_byte_rand(8'h0F);
        send_byte_rand(8'($urandom));
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 2, 2);
        exit_cfg();
        check_writes("abort");
        check_status("abort");

        // Re-entry restarts at address 0; long strobe is a single bit; ena=0 ignores strobes
        enter_cfg();
        send_byte_rand(8'($urandom));
        send_bit(1'b1, 50, 2);
        for (int i = 1; i < 8; i++) send_bit(1'($urandom), 2, 2);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 2, 2);
        ena = 1'b1;
        send_byte_rand(8'($urandom));
        check_writes("glitch_ena");
        check_status("glitch_ena");

        // Asynchronous reset part-way through a byte
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 2, 2);
        rst_n = 1'b0;
        cfg_mode = 1'b0;
        model_exit();
        m_done = 0; m_ovf = 0; m_ptr = 0;
        exp_q.delete();
        #1;
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_wr_addr", wr_addr, 6'd0);
        chk("midrst_wr_data", wr_data, 8'd0);
        check_status("midrst");
        obs_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        enter_cfg();
        repeat (8) @(negedge clk);
        check_writes("post_rst_quiet");
        send_byte_rand(8'($urandom));
        check_writes("post_rst");
        check_status("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
